// File: rtl/mem_copy_engine_pkg.sv
// Shared constants and FSM encoding for the memory copy engine.
package mem_copy_engine_pkg;

    localparam int unsigned DEPTH_DEFAULT = 64;
    localparam int unsigned LEN_W         = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_copy_addr_gen.sv
// Word index counter plus modulo-DEPTH source/destination address adders.
// Bases are expected already reduced modulo DEPTH.
module mem_copy_addr_gen
    import mem_copy_engine_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic [LEN_W-1:0]  idx,
    output logic [ADDR_W-1:0] rd_next_c,
    output logic [ADDR_W-1:0] wr_addr_c
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    // base < DEPTH and offset <= DEPTH, so one conditional subtract wraps
    function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0] base,
                                                   input logic [LEN_W-1:0]  off);
        logic [ADDR_W-1:0] sum;
        sum = base + ADDR_W'(off);
        return (sum >= DEPTH_A) ? (sum - DEPTH_A) : sum;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc) begin
            idx <= idx + LEN_W'(1);
        end
    end

    // read of the next word is issued in the same edge that bumps idx
    assign rd_next_c = wrap_add(src_base, idx + LEN_W'(1));
    assign wr_addr_c = wrap_add(dst_base, idx);

endmodule

// File: rtl/mem_copy_engine.sv
// Word-by-word memory copy engine: one READ then one WRITE cycle per word.
// Optional running checksum of written words with MEM_COPY_CHECKSUM_EN.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy,
    output logic              done
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
    localparam logic [LEN_W-1:0]  DEPTH_L = LEN_W'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx;
    logic [ADDR_W-1:0] rd_next_c, wr_addr_c;
    logic [LEN_W-1:0]  len_cl_c;
    logic [ADDR_W-1:0] src_wrap_c, dst_wrap_c;
    logic              capture, idx_clr, idx_inc;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic              mem_read_d, mem_write_d, busy_d, done_d;

    assign len_cl_c   = (len > DEPTH_L) ? DEPTH_L : len;
    assign src_wrap_c = src % DEPTH_A;
    assign dst_wrap_c = dst % DEPTH_A;

    mem_copy_addr_gen #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .clr       (idx_clr),
        .inc       (idx_inc),
        .src_base  (src_q),
        .dst_base  (dst_q),
        .idx       (idx),
        .rd_next_c (rd_next_c),
        .wr_addr_c (wr_addr_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are computed for the state being entered and registered,
    // so each strobe/address lines up exactly with its state cycle.
    always_comb begin
        state_d     = state_q;
        addr_d      = '0;
        wdata_d     = '0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        capture     = 1'b0;
        idx_clr     = 1'b0;
        idx_inc     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    idx_clr = 1'b1;
                    if (len_cl_c != '0) begin
                        state_d    = READ;
                        addr_d     = src_wrap_c;
                        mem_read_d = 1'b1;
                        busy_d     = 1'b1;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            READ: begin
                state_d     = WRITE;
                addr_d      = wr_addr_c;
                wdata_d     = read_data;
                mem_write_d = 1'b1;
                busy_d      = 1'b1;
            end
            WRITE: begin
                idx_inc = 1'b1;
                if (idx + LEN_W'(1) == len_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d    = READ;
                    addr_d     = rd_next_c;
                    mem_read_d = 1'b1;
                    busy_d     = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
        end else if (capture) begin
            src_q <= src_wrap_c;
            dst_q <= dst_wrap_c;
            len_q <= len_cl_c;
        end
    end

    // write_data doubles as the hold register for the word in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr       <= '0;
            write_data <= '0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            addr       <= addr_d;
            write_data <= wdata_d;
            MemRead    <= mem_read_d;
            MemWrite   <= mem_write_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            checksum <= '0;
        end else if (capture) begin
            checksum <= '0;
        end else if (state_q == WRITE) begin
            checksum <= checksum + write_data;
        end
    end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine against a word-list copy model.
// Checks the checksum port too when MEM_COPY_CHECKSUM_EN is defined.
module tb_mem_copy_engine;
    import mem_copy_engine_pkg::*;

    localparam int unsigned D   = 64;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned AIW = $clog2(D);

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    src = '0;
    logic [AW-1:0]    dst = '0;
    logic [LEN_W-1:0] len = '0;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    write_data;
    logic             MemWrite, MemRead;
    logic [DW-1:0]    read_data;
    logic             busy, done;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DW-1:0]    checksum;
`endif

    mem_copy_engine #(.DEPTH(D), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src        (src),
        .dst        (dst),
        .len        (len),
        .addr       (addr),
        .write_data (write_data),
        .MemWrite   (MemWrite),
        .MemRead    (MemRead),
        .read_data  (read_data),
        .busy       (busy),
        .done       (done)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Memory: combinational read, write on posedge
    logic [DW-1:0] mem [D];
    logic          preload = 1'b0;
    always @(posedge clk) begin
        if (preload) begin
            for (int k = 0; k < int'(D); k++) mem[k] <= DW'(k);
        end else if (MemWrite) begin
            mem[AIW'(addr % AW'(D))] <= write_data;
        end
    end
    assign read_data = mem[AIW'(addr % AW'(D))];

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] ref_mem [D];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_preload();
        @(negedge clk) preload = 1'b1;
        @(negedge clk) preload = 1'b0;
        for (int k = 0; k < int'(D); k++) ref_mem[k] = DW'(k);
    endtask

    function automatic int wrapi(input logic [AW-1:0] base, input int off);
        return int'((base + AW'(off)) % AW'(D));
    endfunction

    function automatic int image_diffs();
        int n = 0;
        for (int k = 0; k < int'(D); k++) if (mem[k] !== ref_mem[k]) n++;
        return n;
    endfunction

    // Caller is just past a negedge with the engine idle.
    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                            input logic [LEN_W-1:0] l, input bit poke_in, input string tag);
        int            L, cyc, done_cyc, nrd, nwr, both, busy_cnt, bad_rd, bad_wr;
        bit            poke;
        logic [DW-1:0] exp_w [$];
        logic [DW-1:0] csum, v;
        L = int'(l);
        if (L > int'(D)) L = int'(D);
        poke = poke_in && (L >= 2);
        csum = '0;
        for (int k = 0; k < L; k++) begin
            v = ref_mem[wrapi(s, k)];
            ref_mem[wrapi(d, k)] = v;
            exp_w.push_back(v);
            csum = csum + v;
        end
        src = s; dst = d; len = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0; done_cyc = -1; nrd = 0; nwr = 0; both = 0; busy_cnt = 0; bad_rd = 0; bad_wr = 0;
        while (cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (MemRead) begin
                if (addr !== AW'(wrapi(s, nrd))) bad_rd++;
                nrd++;
            end
            if (MemWrite) begin
                if (nwr >= L || addr !== AW'(wrapi(d, nwr)) || write_data !== exp_w[nwr]) bad_wr++;
                nwr++;
            end
            if (MemRead && MemWrite) both++;
            if (busy) busy_cnt++;
            if (poke && cyc == 1) begin
                start = 1'b1; src = $urandom; dst = $urandom; len = LEN_W'($urandom);
            end
            if (poke && cyc == 2) start = 1'b0;
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        check({tag, "/done_cycle"}, 64'(done_cyc), 64'(2 * L + 1));
        check({tag, "/reads"},      64'(nrd),      64'(L));
        check({tag, "/writes"},     64'(nwr),      64'(L));
        check({tag, "/rd_wr_both"}, 64'(both),     64'd0);
        check({tag, "/busy_cyc"},   64'(busy_cnt), 64'(2 * L));
        check({tag, "/rd_addr"},    64'(bad_rd),   64'd0);
        check({tag, "/wr_seq"},     64'(bad_wr),   64'd0);
        @(negedge clk);
        check({tag, "/idle_after"}, 64'({done, busy, MemRead, MemWrite, addr, write_data} != '0), 64'd0);
        check({tag, "/mem_image"},  64'(image_diffs()), 64'd0);
`ifdef MEM_COPY_CHECKSUM_EN
        check({tag, "/checksum"},   64'(checksum), 64'(csum));
`endif
    endtask

    initial begin
        int            n_acc, n_done;
        logic [AW-1:0] rs, rd;
        logic [LEN_W-1:0] rl;

        rst = 1'b0;
        #1;
        check("reset_outputs", 64'({done, busy, MemRead, MemWrite, addr, write_data} != '0), 64'd0);
        #20;
        @(negedge clk) rst = 1'b1;

        do_preload();
        run_copy(AW'(0),  AW'(40), LEN_W'(4), 1'b0, "basic");
        do_preload();
        run_copy(AW'(0),  AW'(0),  LEN_W'(0), 1'b0, "len0");
        do_preload();
        run_copy(AW'(62), AW'(10), LEN_W'(4), 1'b0, "wrap");
        do_preload();
        run_copy(AW'(0),  AW'(1),  LEN_W'(3), 1'b1, "overlap");
        do_preload();
        run_copy(AW'(1),  AW'(50), LEN_W'(3), 1'b0, "csum3");
        run_copy(AW'(7),  AW'(9),  LEN_W'(0), 1'b0, "csum_clr");
        do_preload();
        run_copy(AW'(5),  AW'(9),  LEN_W'(100), 1'b0, "clamp");

        // Reset asserted in the WRITE cycle of word 1 (cycle 4)
        do_preload();
        ref_mem[40] = '0;
        src = AW'(0); dst = AW'(40); len = LEN_W'(4); start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        check("rst/pre_write", 64'({MemWrite, addr}), 64'({1'b1, AW'(41)}));
        rst = 1'b0;
        #1;
        check("rst/async_zero", 64'({done, busy, MemRead, MemWrite, addr, write_data} != '0), 64'd0);
        n_acc = 0; n_done = 0;
        repeat (2) begin
            @(negedge clk);
            if (MemRead || MemWrite || busy) n_acc++;
            if (done) n_done++;
        end
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (MemRead || MemWrite || busy) n_acc++;
            if (done) n_done++;
        end
        check("rst/no_access", 64'(n_acc),  64'd0);
        check("rst/no_done",   64'(n_done), 64'd0);
        check("rst/mem_image", 64'(image_diffs()), 64'd0);

        // Random copies over the live memory image
        do_preload();
        for (int t = 0; t < 24; t++) begin
            rs = $urandom;
            rd = $urandom;
            rl = ($urandom_range(0, 5) == 0) ? LEN_W'($urandom_range(0, 127))
                                             : LEN_W'($urandom_range(0, 12));
            run_copy(rs, rd, rl, 1'($urandom_range(0, 1)), $sformatf("rand%0d", t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
